// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use / branch-flush / memory-wait pipeline hazard controller.
// Optional stall-cycle counter enabled by defining HAZARD_STALL_CNT_EN.
module hazard_ctrl #(
  parameter int unsigned LOAD_USE_STALLS = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rt,
  input  logic        ex_memread,
  input  logic [4:0]  ex_rt,
  input  logic        mem_branch_taken,
  input  logic        mem_busy,
  output logic        pc_write,
  output logic        ifid_write,
  output logic        ifid_flush,
  output logic        idex_bubble,
  output logic        exmem_flush,
  output logic        pipe_hold,
  output logic [1:0]  state,
  output logic [15:0] stall_cnt
);
  typedef enum logic [1:0] {RUN = 2'b00, LU_STALL = 2'b01, MEM_WAIT = 2'b10, FLUSH = 2'b11} state_t;
  state_t     st, st_nx;
  logic [2:0] cnt, cnt_nx;
  logic       hazard, stalling;
  assign hazard = ex_memread & (ex_rt != 5'd0) & ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)));
  // A memory wait that interrupted a load-use stall resumes the remaining bubbles.
  assign stalling = (st == LU_STALL) | ((st == MEM_WAIT) & (cnt != 3'd0));
  assign state = st;
  always_comb begin
    pc_write    = 1'b0;
    ifid_write  = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    exmem_flush = 1'b0;
    pipe_hold   = 1'b0;
    st_nx       = st;
    cnt_nx      = cnt;
    if (!reset) begin
      st_nx  = RUN;
      cnt_nx = 3'd0;
    end else if (mem_busy) begin
      pipe_hold = 1'b1;
      st_nx     = MEM_WAIT;
    end else if (mem_branch_taken) begin
      pc_write    = 1'b1;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      exmem_flush = 1'b1;
      st_nx       = FLUSH;
      cnt_nx      = 3'd0;
    end else if (stalling) begin
      idex_bubble = 1'b1;
      cnt_nx      = cnt - 3'd1;
      st_nx       = (cnt == 3'd1) ? RUN : LU_STALL;
    end else if (st == FLUSH) begin
      pc_write   = 1'b1;
      ifid_write = 1'b1;
      st_nx      = RUN;
    end else begin
      pc_write    = ~hazard;
      ifid_write  = ~hazard;
      idex_bubble = hazard;
      st_nx       = (hazard && LOAD_USE_STALLS > 1) ? LU_STALL : RUN;
      cnt_nx      = (hazard && LOAD_USE_STALLS > 1) ? 3'(LOAD_USE_STALLS - 1) : 3'd0;
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st  <= RUN;
      cnt <= 3'd0;
    end else begin
      st  <= st_nx;
      cnt <= cnt_nx;
    end
  end
`ifdef HAZARD_STALL_CNT_EN
  logic [15:0] sc;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sc <= 16'h0000;
    else if (!pc_write && sc != 16'hFFFF) sc <= sc + 16'h0001;
  end
  assign stall_cnt = sc;
`else
  assign stall_cnt = 16'h0000;
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: random + directed check of hazard_ctrl (LOAD_USE_STALLS=1 and 3) against a behavioural model.
module tb_hazard_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [4:0] id_rs = '0, id_rt = '0, ex_rt = '0;
  logic id_uses_rt = 1'b0, ex_memread = 1'b0, mem_branch_taken = 1'b0, mem_busy = 1'b0;
  logic [1:0] pw, fw, ff, bb, ef, ph;
  logic [1:0] st0, st1;
  logic [15:0] sc0, sc1;
  int tests = 0, fails = 0;
  int lcfg [2] = '{1, 3};
  int rem [2] = '{0, 0};
  int msc [2] = '{0, 0};
  bit after_br [2] = '{0, 0};
  bit was_busy [2] = '{0, 0};
  always #5 clk = ~clk;
  hazard_ctrl #(.LOAD_USE_STALLS(1)) u1 (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_memread(ex_memread), .ex_rt(ex_rt), .mem_branch_taken(mem_branch_taken), .mem_busy(mem_busy),
    .pc_write(pw[0]), .ifid_write(fw[0]), .ifid_flush(ff[0]), .idex_bubble(bb[0]),
    .exmem_flush(ef[0]), .pipe_hold(ph[0]), .state(st0), .stall_cnt(sc0));
  hazard_ctrl #(.LOAD_USE_STALLS(3)) u3 (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_memread(ex_memread), .ex_rt(ex_rt), .mem_branch_taken(mem_branch_taken), .mem_busy(mem_busy),
    .pc_write(pw[1]), .ifid_write(fw[1]), .ifid_flush(ff[1]), .idex_bubble(bb[1]),
    .exmem_flush(ef[1]), .pipe_hold(ph[1]), .state(st1), .stall_cnt(sc1));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask
  task automatic cycle(input logic [4:0] rs, input logic [4:0] rt, input logic ut, input logic mr,
                       input logic [4:0] ert, input logic br, input logic bz, input logic rn);
    bit hz, stall_c;
    logic [5:0] ctl;
    logic [1:0] est;
    @(negedge clk);
    id_rs = rs; id_rt = rt; id_uses_rt = ut; ex_memread = mr; ex_rt = ert;
    mem_branch_taken = br; mem_busy = bz; reset = rn;
    #1;
    hz = mr && ert != 0 && (ert == rs || (ut && ert == rt));
    for (int i = 0; i < 2; i++) begin
      est = was_busy[i] ? 2'd2 : after_br[i] ? 2'd3 : (rem[i] > 0) ? 2'd1 : 2'd0;
      stall_c = 0;
      if (!rn) ctl = 6'b000000;
      else if (bz) ctl = 6'b000001;
      else if (br) ctl = 6'b101110;
      else if (rem[i] > 0) begin ctl = 6'b000100; stall_c = 1; end
      else if (after_br[i]) ctl = 6'b110000;
      else if (hz) begin ctl = 6'b000100; stall_c = 1; end
      else ctl = 6'b110000;
      if (!rn) est = 2'd0;
      check($sformatf("ctl%0d{pc,ifw,iff,bub,exf,hold}", lcfg[i]),
            {26'd0, pw[i], fw[i], ff[i], bb[i], ef[i], ph[i]}, {26'd0, ctl});
      check($sformatf("state%0d", lcfg[i]), {30'd0, (i == 0) ? st0 : st1}, {30'd0, est});
`ifdef HAZARD_STALL_CNT_EN
      check($sformatf("stall_cnt%0d", lcfg[i]), {16'd0, (i == 0) ? sc0 : sc1}, (!rn) ? 32'd0 : msc[i]);
`else
      check($sformatf("stall_cnt%0d", lcfg[i]), {16'd0, (i == 0) ? sc0 : sc1}, 32'd0);
`endif
      if (!rn) begin
        rem[i] = 0; msc[i] = 0; after_br[i] = 0; was_busy[i] = 0;
      end else begin
        if (ctl[5] == 1'b0 && msc[i] < 16'hFFFF) msc[i]++;
        if (bz) begin
          was_busy[i] = 1; after_br[i] = 0;
        end else begin
          was_busy[i] = 0;
          if (br) begin rem[i] = 0; after_br[i] = 1; end
          else if (rem[i] > 0) rem[i]--;
          else if (after_br[i]) after_br[i] = 0;
          else if (stall_c) rem[i] = lcfg[i] - 1;
        end
      end
    end
  endtask
  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
  endtask
  initial begin
    cycle(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    cycle(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    idle(2);
    for (int k = 0; k < 3; k++) cycle(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1);
    cycle(5'd5, 5'd9, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b1);
    idle(4);
    cycle(5'd7, 5'd5, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b1);
    idle(4);
    cycle(5'd5, 5'd1, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b1);
    idle(3);
    cycle(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    cycle(5'd5, 5'd9, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) cycle(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
    idle(4);
    cycle(5'd5, 5'd9, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b1);
    cycle(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    idle(3);
    for (int k = 0; k < 3000; k++) begin
      logic [4:0] rs, rt, ert;
      rs = 5'($urandom_range(0, 7));
      rt = 5'($urandom_range(0, 7));
      ert = ($urandom_range(0, 2) == 0) ? rs : 5'($urandom_range(0, 7));
      cycle(rs, rt, 1'($urandom), ($urandom_range(0, 3) != 0), ert,
            ($urandom_range(0, 9) == 0), ($urandom_range(0, 6) == 0), ($urandom_range(0, 79) != 0));
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter LOAD_USE_STALLS, default 1, range 1..7: bubble cycles inserted per load-use hazard.
REQ-002 Port clk  input  1  pipeline clock; all state updates on rising edge.
REQ-003 Port reset  input  1  asynchronous, active-low reset (low = reset asserted).
REQ-004 Port id_rs  input  5  ID-stage instr[25:21].
REQ-005 Port id_rt  input  5  ID-stage instr[20:16].
REQ-006 Port id_uses_rt  input  1  ID instruction reads rt as a source.
REQ-007 Port ex_memread  input  1  MemRead bit of the ID/EX m_ctlout.
REQ-008 Port ex_rt  input  5  ID/EX instrout_2016 (load destination).
REQ-009 Port mem_branch_taken  input  1  branch resolved taken in MEM this cycle.
REQ-010 Port mem_busy  input  1  data memory not ready; pipeline must freeze.
REQ-011 Port pc_write  output  1  PC load enable.
REQ-012 Port ifid_write  output  1  IF/ID load enable.
REQ-013 Port ifid_flush  output  1  IF/ID loads a NOP.
REQ-014 Port idex_bubble  output  1  forces ctlwb_out/ctlm_out/ctlex_out into ID/EX to zero.
REQ-015 Port exmem_flush  output  1  clears EX/MEM control bits.
REQ-016 Port pipe_hold  output  1  freezes ID/EX, EX/MEM, MEM/WB.
REQ-017 Port state  output  2  FSM state: RUN=00, LU_STALL=01, MEM_WAIT=10, FLUSH=11.
REQ-018 Port stall_cnt  output  16  stall-cycle counter (see Configuration).

Function
REQ-019 hazard = ex_memread & (ex_rt!=0) & ((ex_rt==id_rs) | (id_uses_rt & (ex_rt==id_rt))); combinational.
REQ-020 Priority per cycle, any state: mem_busy > mem_branch_taken > hazard.
REQ-021 mem_busy=1 (any state): pc_write=0, ifid_write=0, pipe_hold=1, all flush/bubble 0; next state MEM_WAIT; LU stall count frozen.
REQ-022 MEM_WAIT with mem_busy=0: evaluate as RUN this cycle (Mealy), remembering any unfinished LU_STALL count, which resumes after.
REQ-023 RUN, no event: pc_write=1, ifid_write=1, all other control outputs 0; stay RUN.
REQ-024 mem_branch_taken=1, mem_busy=0: same cycle pc_write=1, ifid_write=0, ifid_flush=1, idex_bubble=1, exmem_flush=1; next state FLUSH; any pending LU stall cancelled.
REQ-025 FLUSH, one cycle: pc_write=1, ifid_write=1, hazard ignored; next state RUN unless mem_busy/branch.
REQ-026 RUN, hazard=1: same cycle pc_write=0, ifid_write=0, idex_bubble=1 (first bubble); if LOAD_USE_STALLS>1 load counter with LOAD_USE_STALLS-1 and go LU_STALL, else stay RUN.
REQ-027 LU_STALL: pc_write=0, ifid_write=0, idex_bubble=1; decrement counter; at counter 1 next state RUN.
REQ-028 Total stall per hazard = exactly LOAD_USE_STALLS cycles, excluding MEM_WAIT freeze cycles.

Reset
REQ-029 reset low: immediately state=RUN, LU counter=0, stall_cnt=0, pc_write=0, ifid_write=0, ifid_flush=0, idex_bubble=0, exmem_flush=0, pipe_hold=0.
REQ-030 Reset mid-stall or mid-flush abandons the sequence; first edge after release evaluates as RUN.

Configuration
REQ-031 Macro HAZARD_STALL_CNT_EN defined: stall_cnt increments by 1 every cycle pc_write=0 outside reset, saturating at 16'hFFFF.
REQ-032 Macro undefined: stall_cnt tied to 16'h0000, no counter register.

Verification
REQ-033 ex_memread=1, ex_rt=5, id_rs=5, LOAD_USE_STALLS=1 -> one cycle pc_write=0, idex_bubble=1, then RUN with pc_write=1.
REQ-034 Same hazard, LOAD_USE_STALLS=3 -> 3 consecutive cycles pc_write=0/idex_bubble=1, state 00->01->01->00.
REQ-035 ex_rt=0, ex_memread=1, id_rs=0 -> no stall, pc_write=1 throughout.
REQ-036 hazard and mem_branch_taken same cycle -> ifid_flush=1, exmem_flush=1, pc_write=1, state FLUSH next, no LU_STALL.
REQ-037 mem_busy high 4 cycles during LU_STALL (LOAD_USE_STALLS=3) -> pipe_hold=1 for 4 cycles, remaining bubbles resume after; with HAZARD_STALL_CNT_EN stall_cnt=7.
REQ-038 reset low mid-LU_STALL -> outputs per REQ-029 immediately, state=00, stall_cnt=0.
